// File: rtl/reset_sequencer_if.sv
// Bundle of the reset sequencer's lock input and generated reset/status outputs.
// master: the sequencer itself. slave: whoever drives lock and consumes resets.
interface reset_sequencer_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  i_pll_lock;
  logic                  o_rst_core;
  logic                  o_rst_periph;
  logic                  o_ready;
  logic [LOSS_CNT_W-1:0] o_lock_loss_cnt;
  logic                  o_timeout;

  modport master (
    input  i_pll_lock,
    output o_rst_core,
    output o_rst_periph,
    output o_ready,
    output o_lock_loss_cnt,
    output o_timeout
  );

  modport slave (
    output i_pll_lock,
    input  o_rst_core,
    input  o_rst_periph,
    input  o_ready,
    input  o_lock_loss_cnt,
    input  o_timeout
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset generator downstream of the PLL. Core reset releases after the
// synchronized lock has been stable for LOCK_STABLE_CYCLES; peripheral reset
// releases STAGE_GAP_CYCLES later. Losing lock after release re-asserts both
// resets, bumps a saturating loss counter and restarts the sequence.
// Optional macro RESET_SEQ_TIMEOUT_EN adds a sticky lock-acquire timeout flag;
// without it o_timeout is constant low.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int LOSS_CNT_W         = 8,
  parameter int TIMEOUT_CYCLES     = 1048576
) (
  input  logic                i_sys_clk,
  input  logic                i_rst,
  reset_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_CORE,
    RUN,
    LOST
  } state_t;

  // One shared stage counter, sized for the longer of the two stages.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                           LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = {LOSS_CNT_W{1'b1}};

  logic                  sync1_q;
  logic                  lock_s_q;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  rst_core_q, rst_core_d;
  logic                  rst_periph_q, rst_periph_d;
  logic                  ready_q, ready_d;

  // Two-flop synchronizer for the lock indication; only lock_s_q is used below.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.i_pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // Sequencer state, stage counter, loss counter and registered outputs.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      loss_q       <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      ready_q      <= ready_d;
    end
  end

  // Next state; a lock drop always wins over a stage counter terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = REL_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_CORE: begin
        if (!lock_s_q) begin
          state_d = LOST;
          cnt_d   = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = LOST;
          cnt_d   = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
        end
      end
      LOST: begin
        // Forced extra cycle in reset so the pulse is at least two cycles wide.
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the state being entered, so they change on the same edge.
  always_comb begin
    rst_core_d   = !((state_d == REL_CORE) || (state_d == RUN));
    rst_periph_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  assign bus.o_rst_core      = rst_core_q;
  assign bus.o_rst_periph    = rst_periph_q;
  assign bus.o_ready         = ready_q;
  assign bus.o_lock_loss_cnt = loss_q;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;

  // Acquire timer: runs while waiting for lock, survives STABLE bounces,
  // clears when the core is released; the flag is sticky until i_rst.
  always_comb begin
    timer_d   = timer_q;
    timeout_d = timeout_q;
    if ((state_q == WAIT_LOCK) || (state_q == STABLE)) begin
      if (state_d == REL_CORE) begin
        timer_d = '0;
      end else if (timer_q != TMR_LAST) begin
        timer_d = timer_q + 1'b1;
      end
    end
    if (timer_d == TMR_LAST) timeout_d = 1'b1;
  end

  // Timer and sticky timeout flag registers.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  // No timer in this build: the flag is constant low (the comparison is
  // always false for any legal TIMEOUT_CYCLES).
  assign bus.o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4,
// LOSS_CNT_W=2, TIMEOUT_CYCLES=32. A streak-based model is checked every
// cycle; directed steps also check hand-computed edge timings.
module tb_reset_sequencer;
  localparam int LSC = 8;
  localparam int GAP = 4;
  localparam int LW  = 2;
  localparam int TO  = 32;
  localparam int LOSS_SAT = (1 << LW) - 1;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reset_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES  (GAP),
    .LOSS_CNT_W        (LW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .i_sys_clk(clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("[TB] check %s: %0d ok", name, got);
    end
  endtask

  // Advance n clock edges, then settle 2 time units past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_loss();
    tick(16);
    bus.i_pll_lock = 1'b0;
    tick(1);
    bus.i_pll_lock = 1'b1;
    tick(2);
  endtask

  // Model: a released sequence is defined purely by how many consecutive
  // synchronized-lock-high edges have been seen since the last restart.
  initial begin : model_compare
    int  streak, loss, tmr, cyc;
    bit  dead, to_m, p1, p2, ls, pend_lock, pend_rst, was_unrel;
    logic [4+LW:0] exp_v, got_v;
    streak = 0; loss = 0; tmr = 0; cyc = 0;
    dead = 0; to_m = 0; p1 = 0; p2 = 0; pend_lock = 0; pend_rst = 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || pend_rst) begin
        streak = 0; loss = 0; tmr = 0; dead = 0; to_m = 0; p1 = 0; p2 = 0;
      end else begin
        ls = p2; p2 = p1; p1 = pend_lock;
        was_unrel = !dead && (streak <= LSC);
        if (was_unrel) begin
          if (ls && streak == LSC) tmr = 0;
          else tmr++;
          if (TO_EN && tmr >= TO) to_m = 1;
        end
        if (dead) begin
          dead = 0; streak = 0;
        end else if (ls) begin
          streak++;
        end else begin
          if (streak > LSC) begin
            loss = (loss < LOSS_SAT) ? loss + 1 : LOSS_SAT;
            dead = 1;
          end
          streak = 0;
        end
      end
      pend_rst  = rst;
      pend_lock = bus.i_pll_lock;
      exp_v = {(streak <= LSC), (streak < LSC + 1 + GAP), (streak >= LSC + 1 + GAP),
               LW'(loss), to_m};
      got_v = {bus.o_rst_core, bus.o_rst_periph, bus.o_ready, bus.o_lock_loss_cnt,
               bus.o_timeout};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL cycle %0d {core,periph,ready,cnt,to}: got %b, expected %b",
                 cyc, got_v, exp_v);
      end
    end
  end

  initial begin : stimulus
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.i_pll_lock = 1'b0;
    tick(3);
    chk("reset core", bus.o_rst_core, 1);
    chk("reset periph", bus.o_rst_periph, 1);
    chk("reset ready", bus.o_ready, 0);
    chk("reset losscnt", bus.o_lock_loss_cnt, 0);
    chk("reset timeout", bus.o_timeout, 0);
    rst = 1'b0;

    // Steady lock: core falls on the 11th edge counting the sampling edge.
    bus.i_pll_lock = 1'b1;
    tick(10); chk("edge10 core held", bus.o_rst_core, 1);
    tick(1);  chk("edge11 core released", bus.o_rst_core, 0);
              chk("edge11 periph held", bus.o_rst_periph, 1);
    tick(3);  chk("edge14 periph held", bus.o_rst_periph, 1);
              chk("edge14 ready low", bus.o_ready, 0);
    tick(1);  chk("edge15 periph released", bus.o_rst_periph, 0);
              chk("edge15 ready", bus.o_ready, 1);
              chk("edge15 losscnt", bus.o_lock_loss_cnt, 0);

    // One-cycle lock drop in RUN.
    bus.i_pll_lock = 1'b0;
    tick(1);
    bus.i_pll_lock = 1'b1;
    tick(1); chk("drop edge2 core", bus.o_rst_core, 0);
    tick(1); chk("drop edge3 core", bus.o_rst_core, 1);
             chk("drop edge3 periph", bus.o_rst_periph, 1);
             chk("drop edge3 ready", bus.o_ready, 0);
             chk("drop edge3 losscnt", bus.o_lock_loss_cnt, 1);
    tick(1); chk("drop edge4 core still", bus.o_rst_core, 1);
    tick(8); chk("drop edge12 core", bus.o_rst_core, 1);
    tick(1); chk("drop edge13 core released", bus.o_rst_core, 0);

    // Saturation of the 2-bit loss counter: 2,3,3,3.
    for (int i = 0; i < 4; i++) begin
      do_loss();
      chk($sformatf("loss %0d count", i + 2), bus.o_lock_loss_cnt,
          (i + 2 > LOSS_SAT) ? LOSS_SAT : i + 2);
    end

    // Asynchronous reset in the middle of REL_CORE.
    tick(10); chk("relcore core", bus.o_rst_core, 0);
              chk("relcore periph", bus.o_rst_periph, 1);
    tick(1);
    rst = 1'b1;
    #1;
    chk("async core", bus.o_rst_core, 1);
    chk("async periph", bus.o_rst_periph, 1);
    chk("async ready", bus.o_ready, 0);
    chk("async losscnt", bus.o_lock_loss_cnt, 0);
    bus.i_pll_lock = 1'b0;
    tick(1);
    rst = 1'b0;

    // Lock held low: timeout flag (if built in) rises on edge 32.
    tick(31); chk("lowlock edge31 timeout", bus.o_timeout, 0);
    tick(1);  chk("lowlock edge32 timeout", bus.o_timeout, TO_EN ? 1 : 0);
    tick(8);  chk("lowlock edge40 timeout", bus.o_timeout, TO_EN ? 1 : 0);

    // Lock glitch of 5 cycles, then steady lock.
    bus.i_pll_lock = 1'b1;
    tick(5); chk("glitch high core", bus.o_rst_core, 1);
    bus.i_pll_lock = 1'b0;
    tick(4); chk("glitch low core", bus.o_rst_core, 1);
    bus.i_pll_lock = 1'b1;
    tick(10); chk("relock edge10 core", bus.o_rst_core, 1);
    tick(1);  chk("relock edge11 core", bus.o_rst_core, 0);
              chk("relock losscnt", bus.o_lock_loss_cnt, 0);
              chk("relock timeout sticky", bus.o_timeout, TO_EN ? 1 : 0);
    tick(20); chk("relock ready", bus.o_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
